board_ram_writer: RTL and testbench



---
 rtl/board_ram_writer.sv | 239 +++++++++++++++++++++++
 tb/tb_board_ram_writer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ram_writer.sv
// Write-side controller for one 2-bit-per-tile board RAM: CLEAR board, PLACE ship, FIRE shot.
// Runs read-check-write sequences on a synchronous-read RAM port and tracks un-hit SHIP tiles.
module board_ram_writer #(
  parameter int unsigned GRID    = 10,
  parameter int unsigned MAX_LEN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_x,
  input  logic [3:0] cmd_y,
  input  logic [2:0] cmd_len,
  input  logic       cmd_vert,
  output logic [9:0] ram_addr,
  output logic [1:0] ram_wdata,
  output logic       ram_we,
  input  logic [1:0] ram_rdata,
  output logic       done,
  output logic [2:0] result,
  output logic [6:0] ships_left
);

  localparam int unsigned CW  = 4;
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned LW  = 3;
  localparam int unsigned LW1 = LW + 1;
  localparam int unsigned SW  = 7;

  localparam logic [CW1-1:0] GRID_V    = CW1'(GRID);
  localparam logic [CW-1:0]  LAST      = CW'(GRID - 1);
  localparam logic [LW1-1:0] MAX_LEN_V = LW1'(MAX_LEN);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_PLACE = 2'b01;
  localparam logic [1:0] OP_FIRE  = 2'b10;

  localparam logic [1:0] T_EMPTY = 2'd0;
  localparam logic [1:0] T_MISS  = 2'd1;
  localparam logic [1:0] T_HIT   = 2'd2;
  localparam logic [1:0] T_SHIP  = 2'd3;

  localparam logic [2:0] R_OK     = 3'd0;
  localparam logic [2:0] R_MISS   = 3'd1;
  localparam logic [2:0] R_HIT    = 3'd2;
  localparam logic [2:0] R_REPEAT = 3'd3;
  localparam logic [2:0] R_REJECT = 3'd4;

  typedef enum logic [3:0] {
    IDLE, CLR, CHK_RD, CHK_EV, PLC_WR, F_RD, F_EV, F_WR, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] org_x, org_y, cur_x, cur_y;
  logic [LW-1:0] len, idx;
  logic          vert;
  logic [2:0]    fire_res;
  logic          fire_hit;

  logic [CW1-1:0] end_x_c, end_y_c;
  logic           coord_bad_c, place_bad_c, reject_c;
  logic [CW-1:0]  step_x_c, step_y_c, clr_x_c, clr_y_c;
  logic           last_tile_c, clr_last_c;

  function automatic logic [9:0] tile_addr(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return {2'b00, x, y};
  endfunction

  // Legality of the command currently offered on the handshake
  always_comb begin
    end_x_c     = CW1'(cmd_x) + CW1'(cmd_len);
    end_y_c     = CW1'(cmd_y) + CW1'(cmd_len);
    coord_bad_c = (CW1'(cmd_x) >= GRID_V) || (CW1'(cmd_y) >= GRID_V);
    place_bad_c = (cmd_len == '0) || (LW1'(cmd_len) > MAX_LEN_V) ||
                  (cmd_vert ? (end_y_c > GRID_V) : (end_x_c > GRID_V));
    reject_c    = 1'b1;
    case (cmd_op)
      OP_CLEAR: reject_c = 1'b0;
      OP_PLACE: reject_c = coord_bad_c || place_bad_c;
      OP_FIRE:  reject_c = coord_bad_c;
      default:  reject_c = 1'b1;
    endcase
  end

  // Tile walkers: ship tiles along the extending axis, clear sweep y-inner
  always_comb begin
    step_x_c    = vert ? cur_x : cur_x + CW'(1);
    step_y_c    = vert ? cur_y + CW'(1) : cur_y;
    last_tile_c = (idx == len - LW'(1));
    clr_last_c  = (cur_x == LAST) && (cur_y == LAST);
    clr_x_c     = (cur_y == LAST) ? cur_x + CW'(1) : cur_x;
    clr_y_c     = (cur_y == LAST) ? '0 : cur_y + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= T_EMPTY;
      ram_we     <= 1'b0;
      done       <= 1'b0;
      result     <= R_OK;
      ships_left <= '0;
      org_x      <= '0;
      org_y      <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      len        <= '0;
      idx        <= '0;
      vert       <= 1'b0;
      fire_res   <= R_OK;
      fire_hit   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            org_x     <= cmd_x;
            org_y     <= cmd_y;
            cur_x     <= cmd_x;
            cur_y     <= cmd_y;
            len       <= cmd_len;
            vert      <= cmd_vert;
            idx       <= '0;
            if (reject_c) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= R_REJECT;
            end else if (cmd_op == OP_CLEAR) begin
              state     <= CLR;
              cur_x     <= '0;
              cur_y     <= '0;
              ram_addr  <= '0;
              ram_wdata <= T_EMPTY;
              ram_we    <= 1'b1;
            end else if (cmd_op == OP_PLACE) begin
              state    <= CHK_RD;
              ram_addr <= tile_addr(cmd_x, cmd_y);
            end else begin
              state    <= F_RD;
              ram_addr <= tile_addr(cmd_x, cmd_y);
            end
          end
        end
        CLR: begin
          if (clr_last_c) begin
            state      <= DONE;
            ram_we     <= 1'b0;
            done       <= 1'b1;
            result     <= R_OK;
            ships_left <= '0;
          end else begin
            cur_x    <= clr_x_c;
            cur_y    <= clr_y_c;
            ram_addr <= tile_addr(clr_x_c, clr_y_c);
          end
        end
        CHK_RD: state <= CHK_EV;
        CHK_EV: begin
          if (ram_rdata != T_EMPTY) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= R_REJECT;
          end else if (last_tile_c) begin
            // Footprint is free: rewind to the origin and start writing
            state     <= PLC_WR;
            cur_x     <= org_x;
            cur_y     <= org_y;
            idx       <= '0;
            ram_addr  <= tile_addr(org_x, org_y);
            ram_wdata <= T_SHIP;
            ram_we    <= 1'b1;
          end else begin
            state    <= CHK_RD;
            cur_x    <= step_x_c;
            cur_y    <= step_y_c;
            idx      <= idx + LW'(1);
            ram_addr <= tile_addr(step_x_c, step_y_c);
          end
        end
        PLC_WR: begin
          if (last_tile_c) begin
            state      <= DONE;
            ram_we     <= 1'b0;
            done       <= 1'b1;
            result     <= R_OK;
            ships_left <= ships_left + SW'(len);
          end else begin
            cur_x    <= step_x_c;
            cur_y    <= step_y_c;
            idx      <= idx + LW'(1);
            ram_addr <= tile_addr(step_x_c, step_y_c);
          end
        end
        F_RD: state <= F_EV;
        F_EV: begin
          state <= F_WR;
          case (ram_rdata)
            T_EMPTY: begin
              ram_we    <= 1'b1;
              ram_wdata <= T_MISS;
              fire_res  <= R_MISS;
              fire_hit  <= 1'b0;
            end
            T_SHIP: begin
              ram_we    <= 1'b1;
              ram_wdata <= T_HIT;
              fire_res  <= R_HIT;
              fire_hit  <= 1'b1;
            end
            default: begin
              ram_we   <= 1'b0;
              fire_res <= R_REPEAT;
              fire_hit <= 1'b0;
            end
          endcase
        end
        F_WR: begin
          state  <= DONE;
          ram_we <= 1'b0;
          done   <= 1'b1;
          result <= fire_res;
          // Saturate: stale SHIP tiles can outlive a reset that zeroed the count
          if (fire_hit && (ships_left != '0)) ships_left <= ships_left - SW'(1);
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_ram_writer.sv
// Randomized bench for board_ram_writer: a board-level model predicts RAM traffic, result,
// completion cycle and ship count per command; a per-cycle compare process checks the DUT.
`timescale 1ns/1ps
module tb_board_ram_writer;

  localparam int GRID    = 10;
  localparam int MAX_LEN = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_x = '0, cmd_y = '0;
  logic [2:0] cmd_len = '0;
  logic       cmd_vert = 1'b0;
  logic [9:0] ram_addr;
  logic [1:0] ram_wdata;
  logic       ram_we;
  logic [1:0] ram_rdata = '0;
  logic       done;
  logic [2:0] result;
  logic [6:0] ships_left;

  board_ram_writer #(.GRID(GRID), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_len(cmd_len), .cmd_vert(cmd_vert),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .done(done), .result(result), .ships_left(ships_left)
  );

  always #5 clk = ~clk;

  // Board RAM: synchronous read, data one cycle after the address
  logic [1:0] ram [0:1023];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int cyc; logic [9:0] addr; logic [1:0] data; } wr_t;
  typedef struct { int cyc; logic [9:0] addr; } rd_t;

  logic [1:0] brd [0:GRID-1][0:GRID-1];
  int  m_ships = 0;
  wr_t exp_wr[$];
  rd_t exp_rd[$];
  int  exp_done_cyc = -1;
  int  exp_res = 0;
  int  exp_ships_after = 0;
  int  ready_lo_from = -1, ready_lo_to = -1, ready_hi_cyc = -1;
  int  cur_ships = 0, cur_res = 0;
  bit  checking = 1'b0;

  function automatic logic [9:0] a_of(input int x, input int y);
    return {2'b00, 4'(x), 4'(y)};
  endfunction

  task automatic predict(input int op, input int x, input int y, input int len, input int vert,
                         input int t, output int lat);
    bit rej;
    int dx, dy, tx, ty;
    dx = vert ? 0 : 1;
    dy = vert ? 1 : 0;
    rej = (op == 3) || (op != 0 && (x >= GRID || y >= GRID)) ||
          (op == 1 && (len == 0 || len > MAX_LEN || (vert ? y + len : x + len) > GRID));
    lat = 1;
    exp_res = 4;
    if (!rej) begin
      if (op == 0) begin
        for (int i = 0; i < GRID * GRID; i++)
          exp_wr.push_back('{t + 1 + i, a_of(i / GRID, i % GRID), 2'd0});
        for (int i = 0; i < GRID; i++)
          for (int j = 0; j < GRID; j++) brd[i][j] = 2'd0;
        m_ships = 0;
        lat = GRID * GRID + 1;
        exp_res = 0;
      end else if (op == 1) begin
        lat = -1;
        for (int i = 0; i < len; i++) begin
          tx = x + dx * i;
          ty = y + dy * i;
          exp_rd.push_back('{t + 1 + 2 * i, a_of(tx, ty)});
          if (brd[tx][ty] != 2'd0) begin
            lat = 3 + 2 * i;
            exp_res = 4;
            break;
          end
        end
        if (lat < 0) begin
          for (int i = 0; i < len; i++) begin
            tx = x + dx * i;
            ty = y + dy * i;
            exp_wr.push_back('{t + 2 * len + 1 + i, a_of(tx, ty), 2'd3});
            brd[tx][ty] = 2'd3;
          end
          m_ships += len;
          lat = 3 * len + 1;
          exp_res = 0;
        end
      end else begin
        exp_rd.push_back('{t + 1, a_of(x, y)});
        lat = 4;
        if (brd[x][y] == 2'd0) begin
          exp_wr.push_back('{t + 3, a_of(x, y), 2'd1});
          brd[x][y] = 2'd1;
          exp_res = 1;
        end else if (brd[x][y] == 2'd3) begin
          exp_wr.push_back('{t + 3, a_of(x, y), 2'd2});
          brd[x][y] = 2'd2;
          exp_res = 2;
          if (m_ships > 0) m_ships--;
        end else begin
          exp_res = 3;
        end
      end
    end
    exp_ships_after = m_ships;
  endtask

  // ---------------- compare process ----------------
  wr_t w;
  rd_t r;
  bit  wr_due;
  always @(negedge clk) begin
    if (checking) begin
      wr_due = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
      if (ram_we || wr_due) begin
        chk("write_strobe", ram_we, wr_due);
        if (wr_due) begin
          w = exp_wr.pop_front();
          if (ram_we) begin
            chk("write_addr", ram_addr, w.addr);
            chk("write_data", ram_wdata, w.data);
          end
        end
      end
      if ((exp_rd.size() > 0) && (exp_rd[0].cyc == cyc)) begin
        r = exp_rd.pop_front();
        chk("read_addr", ram_addr, r.addr);
      end
      if (cyc == exp_done_cyc) begin
        chk("done", done, 1);
        chk("result", result, exp_res);
        chk("ships_left_done", ships_left, exp_ships_after);
        chk("writes_pending", exp_wr.size(), 0);
        cur_ships    = exp_ships_after;
        cur_res      = exp_res;
        ready_hi_cyc = cyc + 1;
        exp_done_cyc = -1;
      end else begin
        chk("done_idle", done, 0);
        chk("ships_left_hold", ships_left, cur_ships);
        chk("result_hold", result, cur_res);
      end
      if (cyc >= ready_lo_from && cyc <= ready_lo_to) chk("ready_busy", cmd_ready, 0);
      if (cyc == ready_hi_cyc) chk("ready_after_done", cmd_ready, 1);
    end
  end

  // Independent observation of the DUT for literal latency pins
  int last_done_cyc = -1;
  int wr_count = 0;
  always @(negedge clk) begin
    if (done) last_done_cyc = cyc;
    if (ram_we) wr_count++;
  end

  task automatic do_cmd(input int op, input int x, input int y, input int len, input int vert,
                        output int t);
    int n, lat;
    n = 0;
    t = cyc;
    while (cmd_ready !== 1'b1) begin
      if (n == 300) begin
        chk("ready_timeout", cmd_ready, 1);
        return;
      end
      @(negedge clk);
      n++;
    end
    t = cyc;
    predict(op, x, y, len, vert, t, lat);
    exp_done_cyc  = t + lat;
    ready_lo_from = t + 1;
    ready_lo_to   = t + lat;
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_x     = 4'(x);
    cmd_y     = 4'(y);
    cmd_len   = 3'(len);
    cmd_vert  = vert[0];
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_x     = 4'($urandom);
    cmd_y     = 4'($urandom);
    cmd_len   = 3'($urandom);
    cmd_vert  = 1'($urandom);
    while (cyc <= t + lat) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, cmd_ready, 0);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_ships"}, ships_left, 0);
  endtask

  task automatic resync_model();
    exp_wr.delete();
    exp_rd.delete();
    exp_done_cyc  = -1;
    ready_lo_from = -1;
    ready_lo_to   = -1;
    ready_hi_cyc  = -1;
    m_ships   = 0;
    cur_ships = 0;
    cur_res   = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, w0, rsel, op, x, y, len, vert;

    // Power-on reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);
    chk("por_ready_after_release", cmd_ready, 1);
    resync_model();
    checking = 1'b1;

    // Reject before any RAM access
    do_cmd(2, 10, 0, 0, 0, t);
    chk("fire_oob_latency", last_done_cyc - t, 1);
    chk("fire_oob_result", result, 4);

    // CLEAR: 100 writes, done at t+101
    w0 = wr_count;
    do_cmd(0, 0, 0, 0, 0, t);
    chk("clear_latency", last_done_cyc - t, 101);
    chk("clear_write_count", wr_count - w0, 100);
    chk("clear_result", result, 0);
    chk("clear_ships", ships_left, 0);

    // PLACE horizontal ship
    w0 = wr_count;
    do_cmd(1, 2, 3, 4, 0, t);
    chk("place_latency", last_done_cyc - t, 13);
    chk("place_result", result, 0);
    chk("place_ships", ships_left, 4);
    chk("place_write_count", wr_count - w0, 4);
    chk("ram_023", ram[10'h023], 3);
    chk("ram_053", ram[10'h053], 3);

    // PLACE crossing the first ship
    w0 = wr_count;
    do_cmd(1, 4, 1, 3, 1, t);
    chk("overlap_latency", last_done_cyc - t, 7);
    chk("overlap_result", result, 4);
    chk("overlap_writes", wr_count - w0, 0);
    chk("overlap_ships", ships_left, 4);

    // Off-board end and bad length
    do_cmd(1, 7, 0, 4, 0, t);
    chk("place_end_oob_latency", last_done_cyc - t, 1);
    do_cmd(1, 0, 0, 0, 1, t);
    chk("place_len0_result", result, 4);
    do_cmd(1, 0, 0, 6, 1, t);
    do_cmd(3, 1, 1, 1, 0, t);
    do_cmd(2, 10, 0, 0, 0, t);
    chk("fire_x10_result", result, 4);

    // FIRE sequence
    do_cmd(2, 3, 3, 0, 0, t);
    chk("fire_hit_latency", last_done_cyc - t, 4);
    chk("fire_hit_result", result, 2);
    chk("fire_hit_ships", ships_left, 3);
    chk("ram_033_hit", ram[10'h033], 2);
    w0 = wr_count;
    do_cmd(2, 3, 3, 0, 0, t);
    chk("fire_repeat_result", result, 3);
    chk("fire_repeat_writes", wr_count - w0, 0);
    do_cmd(2, 9, 9, 0, 0, t);
    chk("fire_miss_latency", last_done_cyc - t, 4);
    chk("fire_miss_result", result, 1);
    chk("ram_099_miss", ram[10'h099], 1);

    // Edge-of-board legal placements
    do_cmd(1, 9, 5, 1, 0, t);
    chk("place_edge_result", result, 0);
    do_cmd(1, 5, 5, 5, 1, t);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      rsel = $urandom_range(0, 99);
      op   = (rsel < 3) ? 0 : (rsel < 45) ? 1 : (rsel < 95) ? 2 : 3;
      x    = $urandom_range(0, 11);
      y    = $urandom_range(0, 11);
      len  = $urandom_range(0, 6);
      vert = $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_cmd(op, x, y, len, vert, t);
    end

    // Whole-board contents against the model
    for (int i = 0; i < GRID; i++)
      for (int j = 0; j < GRID; j++)
        chk("board_tile", ram[a_of(i, j)], brd[i][j]);

    // Reset mid-CLEAR: stale SHIP tiles at x=8 survive, count is zeroed
    do_cmd(0, 0, 0, 0, 0, t);
    do_cmd(1, 8, 5, 2, 1, t);
    chk("pre_reset_ships", ships_left, 2);
    checking = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (18) @(negedge clk);
    chk("midclear_writing", ram_we, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midclear");
    repeat (2) @(negedge clk);
    chk("midclear_still_reset_ready", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midclear_ready_after_release", cmd_ready, 1);
    resync_model();
    checking = 1'b1;

    // HIT on a stale SHIP with count already 0 must not underflow
    do_cmd(2, 8, 5, 0, 0, t);
    chk("underflow_result", result, 2);
    chk("underflow_ships", ships_left, 0);
    do_cmd(0, 0, 0, 0, 0, t);
    do_cmd(2, 8, 6, 0, 0, t);
    chk("post_clear_fire_result", result, 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
